ex_muldiv_unit: RTL

//  Iterative RV32 M-extension multiply/divide unit in the execute stage, directly downstream of the ID/EX register.

---
 rtl/ex_muldiv_unit_if.sv | 40 ++++
 rtl/ex_muldiv_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_if
// Handshake/data bundle between the execute stage and the iterative RV32 M
// unit.
//   master : execute-stage side.
//            Drives start, funct3, op_a, op_b and flush.
//            Receives busy, done and result.
//   slave  : multiply/divide unit side (mirror of master).
// Signals:
//   start  - EX holds a valid M-op
//   funct3 - M-op selector (MUL..REMU)
//   op_a   - forwarded rs1
//   op_b   - forwarded rs2
//   flush  - FlushE, aborts the op in flight
//   busy   - stall request to the hazard unit (combinational)
//   done   - one-cycle result-valid pulse
//   result - M-op result, held until the next completion
// ---------------------------------------------------------------------------
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV32 M-extension multiply/divide unit sitting in EX.
//
// Operation
//   - Multiplies: shift-add, one multiplier bit per cycle.
//   - Divides: restoring division, one quotient bit per cycle.
//   - Both work on operand magnitudes; the sign is re-applied at the end.
//   - Divide-by-zero and signed overflow finish straight from acceptance.
//
// Configuration macro: FAST_MUL_EN
//   - Defined: every multiply completes from acceptance through a
//     single-cycle product.
//   - Undefined (default): multiplies iterate like divides.
//
// Ports
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - ex_muldiv_unit_if.slave
//           Inputs:  start, funct3, op_a, op_b, flush
//           Outputs: busy, done, result
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    ex_muldiv_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_r, state_nxt_s;

    logic [CNT_W-1:0]  count_r;
    logic [2:0]        funct3_r;
    logic              neg_r;      // final result must be negated
    logic [XLEN-1:0]   opd_r;      // multiplicand magnitude, or divisor magnitude
    logic [2*XLEN-1:0] acc_r;      // mul: {partial hi, multiplier}; div: quotient/dividend in low half
    logic [XLEN-1:0]   rem_r;      // divide partial remainder (always < divisor)
    logic [XLEN-1:0]   result_r;

    // Acceptance-side decode
    logic            accept_s;
    logic            is_div_s;
    logic            a_signed_s, b_signed_s;
    logic            sa_s, sb_s, neg_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s;
    logic            div_zero_s, ovf_s, early_s;
    logic [XLEN-1:0] early_result_s;

    // Iteration datapath
    logic [XLEN:0]     mul_sum_s;
    logic [2*XLEN-1:0] mul_acc_nxt_s;
    logic [XLEN:0]     div_shift_s, div_trial_s;
    logic              div_qbit_s;
    logic [XLEN-1:0]   div_rem_nxt_s, div_quo_nxt_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s, rem_fix_s, final_s;

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s, fast_fix_s;
`endif

    assign accept_s = (state_r == ST_IDLE) && bus.start && !bus.flush;
    assign bus.busy = accept_s || (state_r == ST_CALC);
    assign bus.done = (state_r == ST_DONE);
    assign bus.result = result_r;

    // Operand signedness, magnitudes and early-out detection for the op in EX
    always_comb begin
        is_div_s   = bus.funct3[2];
        a_signed_s = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed_s = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                     (bus.funct3 == 3'b110);
        sa_s       = a_signed_s && bus.op_a[XLEN-1];
        sb_s       = b_signed_s && bus.op_b[XLEN-1];
        a_mag_s    = sa_s ? (-bus.op_a) : bus.op_a;
        b_mag_s    = sb_s ? (-bus.op_b) : bus.op_b;
        // Remainder takes the dividend's sign; products/quotients the xor.
        if (is_div_s && bus.funct3[1]) begin
            neg_s = sa_s;
        end else begin
            neg_s = sa_s ^ sb_s;
        end
        div_zero_s = is_div_s && (bus.op_b == ZERO);
        ovf_s      = is_div_s && !bus.funct3[0] && (bus.op_a == INT_MIN) &&
                     (bus.op_b == ALL_ONES);
        if (div_zero_s) begin
            early_result_s = bus.funct3[1] ? bus.op_a : ALL_ONES;
        end else if (ovf_s) begin
            early_result_s = bus.funct3[1] ? ZERO : INT_MIN;
        end else begin
            early_result_s = ZERO;
        end
        early_s = div_zero_s || ovf_s;
`ifdef FAST_MUL_EN
        fast_prod_s = {ZERO, a_mag_s} * {ZERO, b_mag_s};
        fast_fix_s  = neg_s ? (-fast_prod_s) : fast_prod_s;
        if (!is_div_s) begin
            early_s        = 1'b1;
            early_result_s = (bus.funct3 == 3'b000) ? fast_fix_s[XLEN-1:0]
                                                    : fast_fix_s[2*XLEN-1:XLEN];
        end else begin
            early_s        = div_zero_s || ovf_s;
        end
`endif
    end

    // One shift-add / restoring-divide step plus final sign correction
    always_comb begin
        mul_sum_s     = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                        (acc_r[0] ? {1'b0, opd_r} : {1'b0, ZERO});
        mul_acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};

        div_shift_s   = {rem_r, acc_r[XLEN-1]};
        div_trial_s   = div_shift_s - {1'b0, opd_r};
        div_qbit_s    = !div_trial_s[XLEN];
        div_rem_nxt_s = div_qbit_s ? div_trial_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
        div_quo_nxt_s = {acc_r[XLEN-2:0], div_qbit_s};

        prod_fix_s    = neg_r ? (-mul_acc_nxt_s) : mul_acc_nxt_s;
        quo_fix_s     = neg_r ? (-div_quo_nxt_s) : div_quo_nxt_s;
        rem_fix_s     = neg_r ? (-div_rem_nxt_s) : div_rem_nxt_s;

        if (funct3_r[2]) begin
            final_s = funct3_r[1] ? rem_fix_s : quo_fix_s;
        end else if (funct3_r == 3'b000) begin
            final_s = prod_fix_s[XLEN-1:0];
        end else begin
            final_s = prod_fix_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = early_s ? ST_DONE : ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (count_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, iteration registers and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= {CNT_W{1'b0}};
            funct3_r <= 3'b000;
            neg_r    <= 1'b0;
            opd_r    <= ZERO;
            acc_r    <= {ZERO, ZERO};
            rem_r    <= ZERO;
            result_r <= ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        funct3_r <= bus.funct3;
                        neg_r    <= neg_s;
                        count_r  <= {CNT_W{1'b0}};
                        rem_r    <= ZERO;
                        if (is_div_s) begin
                            opd_r <= b_mag_s;
                            acc_r <= {ZERO, a_mag_s};
                        end else begin
                            opd_r <= a_mag_s;
                            acc_r <= {ZERO, b_mag_s};
                        end
                        if (early_s) begin
                            result_r <= early_result_s;
                        end
                    end
                end
                ST_CALC: begin
                    if (!bus.flush) begin
                        count_r <= count_r + CNT_W'(1);
                        if (funct3_r[2]) begin
                            acc_r <= {ZERO, div_quo_nxt_s};
                            rem_r <= div_rem_nxt_s;
                        end else begin
                            acc_r <= mul_acc_nxt_s;
                        end
                        if (count_r == CNT_LAST) begin
                            result_r <= final_s;
                        end
                    end
                end
                ST_DONE: begin
                    count_r <= {CNT_W{1'b0}};
                end
                default: begin
                    count_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end
endmodule
